systolic_feed_ctrl: RTL

- Sequencer for the 4x4 systolic matrix-multiply array (`Systolic_Mul`).
- Holds operand matrices A and B, which a host writes element-by-element.
- On `start_i`, clears the array, then streams A rows into `left_i_0/4/8/12` and B columns into `up_i_0..3`, diagonally skewed; then drains the pipeline and pulses `done_o`.
- Replaces hand-skewed bench stimulus with a reusable controller between host and array.

---
 rtl/systolic_ctrl_pkg.sv | 24 ++
 rtl/systolic_skew_sel.sv | 24 ++
 rtl/systolic_feed_ctrl.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/systolic_ctrl_pkg.sv
// Shared types and sizing for the systolic array feed controller.
package systolic_ctrl_pkg;

  localparam int unsigned ARRAY_N    = 4;
  localparam int unsigned IDX_W      = 2;
  localparam int unsigned FEED_STEPS = 2 * ARRAY_N - 1;
  localparam int unsigned STEP_W     = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_FEED  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Address part of a host element write.
  typedef struct packed {
    logic             sel;
    logic [IDX_W-1:0] row;
    logic [IDX_W-1:0] col;
  } wr_addr_t;

endpackage

// File: rtl/systolic_skew_sel.sv
// Picks one lane's element for skew step t: element (t - LANE) when in 0..ARRAY_N-1, else 0.
module systolic_skew_sel
  import systolic_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LANE       = 0
) (
  input  logic [STEP_W-1:0]                  step_i,
  input  logic [ARRAY_N-1:0][DATA_WIDTH-1:0] lane_data_i,
  output logic [DATA_WIDTH-1:0]              sel_data_c
);

  logic [STEP_W:0] offset;

  // Extra MSB of offset flags steps that precede this lane's first element.
  always_comb begin
    sel_data_c = '0;
    offset     = {1'b0, step_i} - (STEP_W+1)'(LANE);
    if (!offset[STEP_W] && (offset[STEP_W-1:0] < STEP_W'(ARRAY_N))) begin
      sel_data_c = lane_data_i[offset[IDX_W-1:0]];
    end
  end

endmodule

// File: rtl/systolic_feed_ctrl.sv
// Sequencer that stores A/B operands and streams them, diagonally skewed, into a 4x4 systolic array.
module systolic_feed_ctrl
  import systolic_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DRAIN_CYCLES = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  wr_en_i,
  input  logic                  wr_sel_i,
  input  logic [1:0]            wr_row_i,
  input  logic [1:0]            wr_col_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  start_i,
  input  logic                  abort_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  sa_clear_o,
  output logic [DATA_WIDTH-1:0] left_o_0,
  output logic [DATA_WIDTH-1:0] left_o_4,
  output logic [DATA_WIDTH-1:0] left_o_8,
  output logic [DATA_WIDTH-1:0] left_o_12,
  output logic [DATA_WIDTH-1:0] up_o_0,
  output logic [DATA_WIDTH-1:0] up_o_1,
  output logic [DATA_WIDTH-1:0] up_o_2,
  output logic [DATA_WIDTH-1:0] up_o_3
);

  typedef logic [ARRAY_N-1:0][ARRAY_N-1:0][DATA_WIDTH-1:0] mat_t;  // [row][col]
  typedef logic [ARRAY_N-1:0][DATA_WIDTH-1:0]               lane_t;

  state_e            state_q, state_d;
  logic [STEP_W-1:0] step_q, step_d;
  mat_t              a_q, a_d, b_q, b_d;
  mat_t              b_cols;
  lane_t             left_q, left_d, up_q, up_d;
  lane_t             left_sel, up_sel;
  logic              busy_q, busy_d, done_q, done_d, clr_q, clr_d;
  logic              wr_ok;
  wr_addr_t          wr_addr;

  // Next state and step counter; the counter restarts at 0 on every state entry.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_CLEAR;
          step_d  = '0;
        end
      end
      ST_CLEAR: begin
        state_d = abort_i ? ST_IDLE : ST_FEED;
        step_d  = '0;
      end
      ST_FEED: begin
        if (abort_i) begin
          state_d = ST_IDLE;
          step_d  = '0;
        end else if (step_q == STEP_W'(FEED_STEPS - 1)) begin
          state_d = ST_DRAIN;
          step_d  = '0;
        end else begin
          step_d = step_q + STEP_W'(1);
        end
      end
      ST_DRAIN: begin
        if (abort_i) begin
          state_d = ST_IDLE;
          step_d  = '0;
        end else if (step_q == STEP_W'(DRAIN_CYCLES - 1)) begin
          state_d = ST_DONE;
          step_d  = '0;
        end else begin
          step_d = step_q + STEP_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        step_d  = '0;
      end
      default: begin
        state_d = ST_IDLE;
        step_d  = '0;
      end
    endcase
  end

  // Host writes land only while the sequencer is not streaming.
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    wr_addr = '{sel: wr_sel_i, row: wr_row_i, col: wr_col_i};
    wr_ok   = (state_q == ST_IDLE) || (state_q == ST_DONE);
    if (wr_en_i && wr_ok) begin
      if (wr_addr.sel) b_d[wr_addr.row][wr_addr.col] = wr_data_i;
      else             a_d[wr_addr.row][wr_addr.col] = wr_data_i;
    end
  end

  // Column view of B so every up lane sees its column as a contiguous vector.
  always_comb begin
    b_cols = '0;
    for (int r = 0; r < int'(ARRAY_N); r++) begin
      for (int c = 0; c < int'(ARRAY_N); c++) begin
        b_cols[IDX_W'(c)][IDX_W'(r)] = b_q[IDX_W'(r)][IDX_W'(c)];
      end
    end
  end

  for (genvar g = 0; g < int'(ARRAY_N); g++) begin : g_lane
    systolic_skew_sel #(
      .DATA_WIDTH(DATA_WIDTH),
      .LANE      (g)
    ) u_sel_a (
      .step_i     (step_d),
      .lane_data_i(a_q[g]),
      .sel_data_c (left_sel[g])
    );

    systolic_skew_sel #(
      .DATA_WIDTH(DATA_WIDTH),
      .LANE      (g)
    ) u_sel_b (
      .step_i     (step_d),
      .lane_data_i(b_cols[g]),
      .sel_data_c (up_sel[g])
    );
  end

  // Outputs derive from next state so they line up with the cycle they describe.
  always_comb begin
    busy_d = (state_d == ST_CLEAR) || (state_d == ST_FEED) || (state_d == ST_DRAIN);
    done_d = (state_d == ST_DONE);
    clr_d  = (state_d == ST_CLEAR);
    left_d = (state_d == ST_FEED) ? left_sel : '0;
    up_d   = (state_d == ST_FEED) ? up_sel   : '0;
  end

  // Sequencer state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
    end
  end

  // Operand storage.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_q <= '0;
      b_q <= '0;
    end else begin
      a_q <= a_d;
      b_q <= b_d;
    end
  end

  // Registered array-facing outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      clr_q  <= 1'b0;
      left_q <= '0;
      up_q   <= '0;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
      clr_q  <= clr_d;
      left_q <= left_d;
      up_q   <= up_d;
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign sa_clear_o = clr_q;
  assign left_o_0   = left_q[0];
  assign left_o_4   = left_q[1];
  assign left_o_8   = left_q[2];
  assign left_o_12  = left_q[3];
  assign up_o_0     = up_q[0];
  assign up_o_1     = up_q[1];
  assign up_o_2     = up_q[2];
  assign up_o_3     = up_q[3];

endmodule
